// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: a chain of DEPTH pipeline-boundary register slots that
// carries an opaque payload with a per-slot valid bit. Every slot obeys the
// global stall vector (bubble / load / hold), a synchronous flush clears all
// slots, and occupancy reports how many slots hold a real instruction.
// Optional performance counters are built only when the macro
// PIPE_STAGE_CHAIN_PERF_EN is defined; otherwise hold_cnt/bubble_cnt read 0.
module pipe_stage_chain #(
  parameter int                DATA_W    = 81,
  parameter int                DEPTH     = 1,
  parameter int                STALL_W   = 6,
  parameter int                STAGE_IDX = 2,
  parameter logic [DATA_W-1:0] NOP_DATA  = '0,
  localparam int               OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [OCC_W-1:0]   occupancy,
  output logic [31:0]        hold_cnt,
  output logic [31:0]        bubble_cnt
);

  // The last slot reads stall[STAGE_IDX+DEPTH], so that bit must exist.
  if ((STAGE_IDX + DEPTH > STALL_W - 1) || (DEPTH < 1) || (DEPTH > 4)) begin : g_param_check
    $error("pipe_stage_chain: illegal DEPTH/STAGE_IDX/STALL_W combination");
  end

  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]  slot_valid;
  logic [DEPTH-1:0]  hold_sel;    // slot keeps its contents this cycle
  logic [DEPTH-1:0]  bubble_sel;  // slot takes a bubble this cycle

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    localparam int SI = STAGE_IDX + gi;

    logic [DATA_W-1:0] data_q, data_d, src_data;
    logic              valid_q, valid_d, src_valid;
    logic              hold_k, bubble_k;

    if (gi == 0) begin : g_src_in
      assign src_data  = in_data;
      assign src_valid = in_valid;
    end else begin : g_src_prev
      assign src_data  = slot_data[gi-1];
      assign src_valid = slot_valid[gi-1];
    end

    // Next-state selection: flush, then bubble, then load, else hold.
    always_comb begin
      data_d   = data_q;
      valid_d  = valid_q;
      hold_k   = 1'b0;
      bubble_k = 1'b0;
      if (flush) begin
        data_d  = NOP_DATA;
        valid_d = 1'b0;
      end else if (stall[SI] && !stall[SI+1]) begin
        data_d   = NOP_DATA;
        valid_d  = 1'b0;
        bubble_k = 1'b1;
      end else if (!stall[SI]) begin
        data_d  = src_data;
        valid_d = src_valid;
      end else begin
        hold_k = 1'b1;
      end
    end

    // Slot register with synchronous reset to the NOP payload.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= NOP_DATA;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign slot_data[gi]  = data_q;
    assign slot_valid[gi] = valid_q;
    assign hold_sel[gi]   = hold_k;
    assign bubble_sel[gi] = bubble_k;
  end

  assign out_data  = slot_data[DEPTH-1];
  assign out_valid = slot_valid[DEPTH-1];

  // Popcount of the slot valid bits.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(slot_valid[k]);
    end
  end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [31:0] hold_cnt_q, bubble_cnt_q;

  // Saturating perf counters; cleared by reset only, flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q   <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if ((|hold_sel) && (hold_cnt_q != 32'hFFFF_FFFF)) begin
        hold_cnt_q <= hold_cnt_q + 32'h1;
      end
      if (bubble_sel[0] && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'h1;
      end
    end
  end

  assign hold_cnt   = hold_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = ^{hold_sel, bubble_sel};
  assign hold_cnt    = 32'h0;
  assign bubble_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a DEPTH=1 and a DEPTH=3 instance share all
// inputs; both are compared every cycle against a slot-array model, with
// directed scenarios followed by randomized stall/flush/reset traffic.
module tb_pipe_stage_chain;
  localparam int DATA_W    = 81;
  localparam int STALL_W   = 6;
  localparam int STAGE_IDX = 2;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;

  logic [DATA_W-1:0]  o1_data, o3_data;
  logic               o1_valid, o3_valid;
  logic               o1_occ;
  logic [1:0]         o3_occ;
  logic [31:0]        o1_hold, o1_bub, o3_hold, o3_bub;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_W(DATA_W), .DEPTH(1), .STALL_W(STALL_W), .STAGE_IDX(STAGE_IDX)) u_d1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .out_data(o1_data), .out_valid(o1_valid), .occupancy(o1_occ),
    .hold_cnt(o1_hold), .bubble_cnt(o1_bub)
  );

  pipe_stage_chain #(.DATA_W(DATA_W), .DEPTH(3), .STALL_W(STALL_W), .STAGE_IDX(STAGE_IDX)) u_d3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .out_data(o3_data), .out_valid(o3_valid), .occupancy(o3_occ),
    .hold_cnt(o3_hold), .bubble_cnt(o3_bub)
  );

  // Reference model: index 0 is the DEPTH=1 chain, index 1 the DEPTH=3 chain.
  int                dep [2] = '{1, 3};
  logic [DATA_W-1:0] md  [2][4];
  logic              mv  [2][4];
  logic [31:0]       mh  [2];
  logic [31:0]       mb  [2];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    logic [DATA_W-1:0] nd [4];
    logic              nv [4];
    logic [DATA_W-1:0] sd;
    logic              sv;
    bit                any_hold, bub0;
    int                si;
    for (int d = 0; d < 2; d++) begin
      any_hold = 0;
      bub0     = 0;
      for (int k = 0; k < dep[d]; k++) begin
        si = STAGE_IDX + k;
        sd = (k == 0) ? in_data  : md[d][k-1];
        sv = (k == 0) ? in_valid : mv[d][k-1];
        if (rst || flush) begin
          nd[k] = '0; nv[k] = 1'b0;
        end else if (stall[si] && !stall[si+1]) begin
          nd[k] = '0; nv[k] = 1'b0;
          if (k == 0) bub0 = 1;
        end else if (!stall[si]) begin
          nd[k] = sd; nv[k] = sv;
        end else begin
          nd[k] = md[d][k]; nv[k] = mv[d][k];
          any_hold = 1;
        end
      end
      for (int k = 0; k < dep[d]; k++) begin
        md[d][k] = nd[k];
        mv[d][k] = nv[k];
      end
      if (!PERF || rst) begin
        mh[d] = 32'h0;
        mb[d] = 32'h0;
      end else begin
        if (any_hold && mh[d] != 32'hFFFF_FFFF) mh[d] = mh[d] + 1;
        if (bub0 && mb[d] != 32'hFFFF_FFFF) mb[d] = mb[d] + 1;
      end
    end
  endtask

  function automatic int model_occ(input int d);
    int n = 0;
    for (int k = 0; k < dep[d]; k++) n += int'(mv[d][k]);
    return n;
  endfunction

  task automatic compare_all();
    check_val("d1_data",  128'(o1_data),  128'(md[0][0]));
    check_val("d1_valid", 128'(o1_valid), 128'(mv[0][0]));
    check_val("d1_occ",   128'(o1_occ),   128'(model_occ(0)));
    check_val("d1_hold",  128'(o1_hold),  128'(mh[0]));
    check_val("d1_bub",   128'(o1_bub),   128'(mb[0]));
    check_val("d3_data",  128'(o3_data),  128'(md[1][2]));
    check_val("d3_valid", 128'(o3_valid), 128'(mv[1][2]));
    check_val("d3_occ",   128'(o3_occ),   128'(model_occ(1)));
    check_val("d3_hold",  128'(o3_hold),  128'(mh[1]));
    check_val("d3_bub",   128'(o3_bub),   128'(mb[1]));
  endtask

  // One clock edge: update model at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  logic [DATA_W-1:0] pat_a5;
  logic [87:0]       pat_wide;

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin md[d][k] = 'x; mv[d][k] = 1'bx; end
      mh[d] = 'x; mb[d] = 'x;
    end
    pat_wide = {11{8'hA5}};
    pat_a5   = pat_wide[DATA_W-1:0];
    rst = 1'b1; stall = '0; flush = 1'b0; in_data = '0; in_valid = 1'b0;
    @(negedge clk);

    // Reset held for two cycles.
    tick(); tick();
    check_val("rst_data",  128'(o1_data),  128'h0);
    check_val("rst_valid", 128'(o1_valid), 128'h0);
    check_val("rst_occ",   128'(o3_occ),   128'h0);
    check_val("rst_hold",  128'(o1_hold),  128'h0);
    check_val("rst_bub",   128'(o1_bub),   128'h0);
    rst = 1'b0;

    // Single-slot load.
    in_data = pat_a5; in_valid = 1'b1;
    tick();
    check_val("load_data", 128'(o1_data), 128'(pat_a5));
    check_val("load_occ",  128'(o1_occ),  128'h1);

    // Both slot-0 stall bits set: payload held for three cycles.
    stall = 6'b001100; in_data = '1;
    tick(); tick(); tick();
    check_val("hold_data", 128'(o1_data), 128'(pat_a5));
    check_val("hold_cnt",  128'(o1_hold), PERF ? 128'd3 : 128'd0);

    // Upstream stalled, downstream running: bubble.
    stall = 6'b000100;
    tick();
    check_val("bub_valid", 128'(o1_valid), 128'h0);
    check_val("bub_data",  128'(o1_data),  128'h0);
    check_val("bub_cnt",   128'(o1_bub),   PERF ? 128'd1 : 128'd0);

    // Three-slot latency and occupancy ramp.
    rst = 1'b1; stall = '0; in_valid = 1'b0; in_data = '0;
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      in_data  = (n <= 3) ? DATA_W'(n) : '0;
      in_valid = (n <= 3);
      tick();
      if (n <= 3) check_val($sformatf("ramp_occ%0d", n), 128'(o3_occ), 128'(n));
      if (n >= 3) check_val($sformatf("lat_data%0d", n), 128'(o3_data), 128'(n - 2));
    end

    // Refill the chain, then flush while every slot is stalled.
    for (int n = 0; n < 3; n++) begin
      in_data = DATA_W'($urandom); in_valid = 1'b1;
      tick();
    end
    check_val("full_occ", 128'(o3_occ), 128'd3);
    flush = 1'b1; stall = 6'b111100;
    tick();
    check_val("flush_occ",   128'(o3_occ),   128'h0);
    check_val("flush_valid", 128'(o3_valid), 128'h0);
    check_val("flush_data",  128'(o3_data),  128'h0);
    flush = 1'b0; stall = '0;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    // Bubble counter saturation from a preloaded value.
    force u_d1.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_d1.bubble_cnt_q;
    mb[0] = 32'hFFFF_FFFE;
    stall = 6'b000100;
    tick(); tick(); tick();
    check_val("bub_sat", 128'(o1_bub), 128'hFFFF_FFFF);
    stall = '0;
`else
    check_val("noperf_hold", 128'(o3_hold), 128'h0);
    check_val("noperf_bub",  128'(o3_bub),  128'h0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      stall    = STALL_W'($urandom);
      in_data  = DATA_W'({$urandom, $urandom, $urandom});
      in_valid = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
